// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes a program image into
// instruction memory and holds the pipeline until the image is in place.
//
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   reload                - restart loading from DONE or ERR
//   in_valid/in_data      - stream byte, transferred when in_ready is high
//   in_ready              - loader accepts a byte this cycle
//   mem_we/addr/wdata     - registered instruction-memory write port
//   cpu_hold              - pipeline frozen while high
//   done / error          - load succeeded / checksum mismatch
module imem_loader #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reload,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0] state;
  logic [7:0] len;
  logic [7:0] count;
  logic [7:0] sum;
  logic [7:0] next_addr;
  logic       xfer;
  logic       last_byte;

  assign in_ready = (state == S_LEN) ||
                    (state == S_DATA) ||
                    (state == S_CHK);
  assign xfer = in_valid && in_ready;

  // len 0 wraps to 8'hFF here, so a zero length means 256 bytes.
  assign last_byte = (count == len - 8'd1);

  // Without a checksum byte the final write strobe lands in the first
  // DONE cycle; keep the pipeline frozen until that write is in memory.
  assign done     = (state == S_DONE) && !mem_we;
  assign cpu_hold = !done;
  assign error    = (state == S_ERR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_LEN;
      len       <= 8'd0;
      count     <= 8'd0;
      sum       <= 8'd0;
      next_addr <= BASE_ADDR;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_LEN: begin
          if (xfer) begin
            len       <= in_data;
            count     <= 8'd0;
            sum       <= 8'd0;
            next_addr <= BASE_ADDR;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= next_addr;
            mem_wdata <= in_data;
            next_addr <= next_addr + 8'd1;
            sum       <= sum + in_data;
            count     <= count + 8'd1;
            if (last_byte)
              state <= CHECKSUM_EN ? S_CHK : S_DONE;
          end
        end
        S_CHK: begin
          if (xfer)
            state <= (in_data == sum) ? S_DONE : S_ERR;
        end
        S_DONE, S_ERR: begin
          if (reload)
            state <= S_LEN;
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Three instances cover base 00 / base 10 / no-checksum builds.
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       reload   [3];
  logic       in_valid [3];
  logic [7:0] in_data  [3];
  logic       in_ready [3];
  logic       mem_we   [3];
  logic [7:0] mem_addr [3];
  logic [7:0] mem_wdata[3];
  logic       cpu_hold [3];
  logic       done     [3];
  logic       error    [3];

  int errors = 0;
  int checks = 0;
  int wcount [3];
  logic [17:0] q [$];

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(8'h00), .CHECKSUM_EN(1'b1)) dut0 (
    .clock(clock), .reset(reset), .reload(reload[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .cpu_hold(cpu_hold[0]), .done(done[0]), .error(error[0]));

  imem_loader #(.BASE_ADDR(8'h10), .CHECKSUM_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .reload(reload[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .cpu_hold(cpu_hold[1]), .done(done[1]), .error(error[1]));

  imem_loader #(.BASE_ADDR(8'h00), .CHECKSUM_EN(1'b0)) dut2 (
    .clock(clock), .reset(reset), .reload(reload[2]),
    .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .mem_we(mem_we[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .cpu_hold(cpu_hold[2]), .done(done[2]), .error(error[2]));

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_we[i]) begin
        logic [17:0] e;
        wcount[i]++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_write dut%0d got [%h]=%h required none",
                   i, mem_addr[i], mem_wdata[i]);
        end else begin
          e = q.pop_front();
          if ({i[1:0], mem_addr[i], mem_wdata[i]} !== e) begin
            errors++;
            $display("FAIL write dut%0d got [%h]=%h required dut%0d [%h]=%h",
                     i, mem_addr[i], mem_wdata[i], e[17:16], e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b,
                      input bit exp_w, input logic [7:0] a);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    if (exp_w) q.push_back({d[1:0], a, b});
    @(posedge clock); #1;
  endtask

  task automatic idle(input int d, input int n);
    in_valid[d] = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      reload[i]   = 1'b0;
      in_data[i]  = 8'h00;
      wcount[i]   = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d writes left required 0",
               name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready[0], cpu_hold[0], mem_we[0], done[0], error[0]}
        !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags got rdy/hold/we/done/err=%b required 11000",
               {in_ready[0], cpu_hold[0], mem_we[0], done[0], error[0]});
    end
    checks++;
    if (mem_addr[1] !== 8'h10 || mem_wdata[1] !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr got %h/%h required 10/00",
               mem_addr[1], mem_wdata[1]);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    send(0, 8'h03, 0, 8'h00);
    send(0, 8'h11, 1, 8'h00);
    send(0, 8'h22, 1, 8'h01);
    send(0, 8'h33, 1, 8'h02);
    send(0, 8'h66, 0, 8'h00);
    checks++;
    if ({done[0], cpu_hold[0], error[0], in_ready[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL good_status got done/hold/err/rdy=%b required 1000",
               {done[0], cpu_hold[0], error[0], in_ready[0]});
    end
    idle(0, 2);
    drain("good");
    checks++;
    if (wcount[0] !== 3) begin
      errors++;
      $display("FAIL good_count got %0d required 3", wcount[0]);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send(0, 8'h03, 0, 8'h00);
    send(0, 8'h11, 1, 8'h00);
    send(0, 8'h22, 1, 8'h01);
    send(0, 8'h33, 1, 8'h02);
    send(0, 8'h67, 0, 8'h00);
    checks++;
    if ({done[0], cpu_hold[0], error[0], in_ready[0]} !== 4'b0110) begin
      errors++;
      $display("FAIL bad_status got done/hold/err/rdy=%b required 0110",
               {done[0], cpu_hold[0], error[0], in_ready[0]});
    end
    send(0, 8'h44, 0, 8'h00);
    idle(0, 2);
    checks++;
    if (error[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bad_hold got err/rdy=%b%b required 10",
               error[0], in_ready[0]);
    end
    drain("bad");
  endtask

  task automatic test_wrap_256();
    do_reset();
    send(1, 8'h00, 0, 8'h00);
    for (int i = 0; i < 256; i++)
      send(1, 8'(i), 1, 8'(8'h10 + i));
    checks++;
    if (done[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_chk got done/rdy=%b%b required 01",
               done[1], in_ready[1]);
    end
    send(1, 8'h80, 0, 8'h00);
    checks++;
    if (done[1] !== 1'b1 || cpu_hold[1] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done got done/hold=%b%b required 10",
               done[1], cpu_hold[1]);
    end
    idle(1, 2);
    drain("wrap");
    checks++;
    if (wcount[1] !== 256) begin
      errors++;
      $display("FAIL wrap_count got %0d required 256", wcount[1]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send(0, 8'h02, 0, 8'h00);
    send(0, 8'hA1, 1, 8'h00);
    reload[0] = 1'b1;
    idle(0, 1);
    reload[0] = 1'b0;
    send(0, 8'hB2, 1, 8'h01);
    idle(0, 1);
    checks++;
    if (mem_we[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL gap_idle got we/rdy=%b%b required 01",
               mem_we[0], in_ready[0]);
    end
    send(0, 8'h53, 0, 8'h00);
    checks++;
    if (done[0] !== 1'b1) begin
      errors++;
      $display("FAIL gap_done got %b required 1", done[0]);
    end
    idle(0, 2);
    drain("gap");
    checks++;
    if (wcount[0] !== 2) begin
      errors++;
      $display("FAIL gap_count got %0d required 2", wcount[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(0, 8'h04, 0, 8'h00);
    send(0, 8'hC1, 1, 8'h00);
    send(0, 8'hC2, 1, 8'h01);
    in_data[0] = 8'hC3;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid[0] = 1'b0;
    checks++;
    if ({in_ready[0], cpu_hold[0], mem_we[0], done[0]} !== 4'b1100) begin
      errors++;
      $display("FAIL midrst_state got rdy/hold/we/done=%b required 1100",
               {in_ready[0], cpu_hold[0], mem_we[0], done[0]});
    end
    send(0, 8'h01, 0, 8'h00);
    send(0, 8'hAA, 1, 8'h00);
    send(0, 8'hAA, 0, 8'h00);
    checks++;
    if (done[0] !== 1'b1 || error[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done got done/err=%b%b required 10",
               done[0], error[0]);
    end
    idle(0, 2);
    drain("midrst");
  endtask

  task automatic test_reload_nochk();
    do_reset();
    send(2, 8'h01, 0, 8'h00);
    send(2, 8'h77, 1, 8'h00);
    in_valid[2] = 1'b0;
    checks++;
    if (mem_we[2] !== 1'b1 || done[2] !== 1'b0 || cpu_hold[2] !== 1'b1) begin
      errors++;
      $display("FAIL nochk_strobe got we/done/hold=%b%b%b required 101",
               mem_we[2], done[2], cpu_hold[2]);
    end
    idle(2, 1);
    checks++;
    if (done[2] !== 1'b1 || cpu_hold[2] !== 1'b0) begin
      errors++;
      $display("FAIL nochk_done1 got done/hold=%b%b required 10",
               done[2], cpu_hold[2]);
    end
    reload[2] = 1'b1;
    @(posedge clock); #1;
    reload[2] = 1'b0;
    checks++;
    if ({done[2], cpu_hold[2], in_ready[2]} !== 3'b011) begin
      errors++;
      $display("FAIL reload_state got done/hold/rdy=%b required 011",
               {done[2], cpu_hold[2], in_ready[2]});
    end
    send(2, 8'h02, 0, 8'h00);
    send(2, 8'h5A, 1, 8'h00);
    send(2, 8'hA5, 1, 8'h01);
    in_valid[2] = 1'b0;
    checks++;
    if (in_ready[2] !== 1'b0 || done[2] !== 1'b0) begin
      errors++;
      $display("FAIL nochk_last got rdy/done=%b%b required 00",
               in_ready[2], done[2]);
    end
    idle(2, 1);
    checks++;
    if (done[2] !== 1'b1 || cpu_hold[2] !== 1'b0 || error[2] !== 1'b0) begin
      errors++;
      $display("FAIL nochk_done2 got done/hold/err=%b%b%b required 100",
               done[2], cpu_hold[2], error[2]);
    end
    idle(2, 1);
    drain("nochk");
    checks++;
    if (wcount[2] !== 3) begin
      errors++;
      $display("FAIL nochk_count got %0d required 3", wcount[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      reload[i]   = 1'b0;
      in_data[i]  = 8'h00;
      wcount[i]   = 0;
    end
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_wrap_256();
    test_gaps();
    test_mid_reset();
    test_reload_nochk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
